// File: rtl/conv2d_scan_ctrl_if.sv
// Tap-descriptor handshake between conv2d_scan_ctrl (master) and the MAC datapath (slave).
interface conv2d_scan_ctrl_if #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3,
    parameter int CH    = 4
);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int HW = (CH > 1) ? $clog2(CH) : 1;

    logic          tap_valid;
    logic          tap_ready;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic [HW-1:0] ch;
    logic [KW-1:0] ky;
    logic [KW-1:0] kx;
    logic [RW-1:0] in_row;
    logic [CW-1:0] in_col;
    logic          pad;
    logic          acc_first;
    logic          acc_last;

    modport master (
        output tap_valid, out_row, out_col, ch, ky, kx, in_row, in_col, pad, acc_first, acc_last,
        input  tap_ready
    );

    modport slave (
        input  tap_valid, out_row, out_col, ch, ky, kx, in_row, in_col, pad, acc_first, acc_last,
        output tap_ready
    );
endinterface

// File: rtl/conv2d_scan_ctrl.sv
// Conv2d loop-nest sequencer: walks out_row/out_col/ch/ky/kx and emits one tap descriptor per step.
// Define CONV_ZERO_PAD_EN for "same" convolution with zero padding; default is "valid" convolution.
module conv2d_scan_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3,
    parameter int CH    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    conv2d_scan_ctrl_if.master tap
);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int HW = (CH > 1) ? $clog2(CH) : 1;
`ifdef CONV_ZERO_PAD_EN
    localparam int OH  = IMG_H;
    localparam int OW  = IMG_W;
    localparam int OFF = (K - 1) / 2;
`else
    localparam int OH  = IMG_H - K + 1;
    localparam int OW  = IMG_W - K + 1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_n;
    logic [RW-1:0] row_n, in_row_n;
    logic [CW-1:0] col_n, in_col_n;
    logic [HW-1:0] ch_n;
    logic [KW-1:0] ky_n, kx_n;
    logic          pad_n, first_n, last_n;
    logic          fire, kx_max, ky_max, ch_max, col_max, row_max;

    assign fire    = tap.tap_valid & tap.tap_ready;
    assign kx_max  = (tap.kx == KW'(K - 1));
    assign ky_max  = (tap.ky == KW'(K - 1));
    assign ch_max  = (tap.ch == HW'(CH - 1));
    assign col_max = (tap.out_col == CW'(OW - 1));
    assign row_max = (tap.out_row == RW'(OH - 1));

    always_comb begin
        state_n = state;
        row_n   = tap.out_row;
        col_n   = tap.out_col;
        ch_n    = tap.ch;
        ky_n    = tap.ky;
        kx_n    = tap.kx;
        case (state)
            IDLE: if (start) begin
                state_n = RUN;
                row_n   = '0;
                col_n   = '0;
                ch_n    = '0;
                ky_n    = '0;
                kx_n    = '0;
            end
            RUN: if (fire) begin
                if (kx_max && ky_max && ch_max && col_max && row_max)
                    state_n = DONE;
                // Odometer carry chain; the final step wraps everything back to zero.
                if (!kx_max) kx_n = tap.kx + KW'(1);
                else begin
                    kx_n = '0;
                    if (!ky_max) ky_n = tap.ky + KW'(1);
                    else begin
                        ky_n = '0;
                        if (!ch_max) ch_n = tap.ch + HW'(1);
                        else begin
                            ch_n = '0;
                            if (!col_max) col_n = tap.out_col + CW'(1);
                            else begin
                                col_n = '0;
                                row_n = row_max ? '0 : tap.out_row + RW'(1);
                            end
                        end
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef CONV_ZERO_PAD_EN
    logic signed [RW+1:0] r_s;
    logic signed [CW+1:0] c_s;

    always_comb begin
        r_s      = $signed({2'b00, row_n}) + $signed((RW+2)'(ky_n)) - $signed((RW+2)'(OFF));
        c_s      = $signed({2'b00, col_n}) + $signed((CW+2)'(kx_n)) - $signed((CW+2)'(OFF));
        pad_n    = r_s[RW+1] || (r_s >= $signed((RW+2)'(IMG_H))) ||
                   c_s[CW+1] || (c_s >= $signed((CW+2)'(IMG_W)));
        in_row_n = pad_n ? '0 : r_s[RW-1:0];
        in_col_n = pad_n ? '0 : c_s[CW-1:0];
    end
`else
    always_comb begin
        pad_n    = 1'b0;
        in_row_n = row_n + RW'(ky_n);
        in_col_n = col_n + CW'(kx_n);
    end
`endif

    assign first_n = (kx_n == '0) && (ky_n == '0) && (ch_n == '0);
    assign last_n  = (kx_n == KW'(K - 1)) && (ky_n == KW'(K - 1)) && (ch_n == HW'(CH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            tap.out_row   <= '0;
            tap.out_col   <= '0;
            tap.ch        <= '0;
            tap.ky        <= '0;
            tap.kx        <= '0;
            tap.in_row    <= '0;
            tap.in_col    <= '0;
            tap.acc_first <= 1'b0;
            tap.acc_last  <= 1'b0;
        end else begin
            state         <= state_n;
            tap.out_row   <= row_n;
            tap.out_col   <= col_n;
            tap.ch        <= ch_n;
            tap.ky        <= ky_n;
            tap.kx        <= kx_n;
            tap.in_row    <= in_row_n;
            tap.in_col    <= in_col_n;
            tap.acc_first <= first_n;
            tap.acc_last  <= last_n;
        end
    end

`ifdef CONV_ZERO_PAD_EN
    always_ff @(posedge clk) begin
        if (!reset) tap.pad <= 1'b0;
        else        tap.pad <= pad_n;
    end
`else
    assign tap.pad = pad_n;
`endif

    // Flags decode the state register directly, so nothing downstream sees tap_ready combinationally.
    assign busy          = (state == RUN);
    assign tap.tap_valid = (state == RUN);
    assign done          = (state == DONE);
endmodule

// File: tb/tb_conv2d_scan_ctrl.sv
// Scoreboard bench for conv2d_scan_ctrl: loop-nest reference model, random backpressure, start/reset corner cases.
module tb_conv2d_scan_ctrl;
    localparam int W = 4;
    localparam int H = 4;
    localparam int K = 3;
`ifdef CONV_ZERO_PAD_EN
    localparam int CH = 2, OFF = 1, OH = H, OW = W;
`else
    localparam int CH = 1, OFF = 0, OH = H - K + 1, OW = W - K + 1;
`endif
    localparam int TOTAL = OH * OW * CH * K * K;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done;
    logic start2 = 1'b0;
    logic busy2, done2;

    conv2d_scan_ctrl_if #(.IMG_W(W), .IMG_H(H), .K(K), .CH(CH)) tif();
    conv2d_scan_ctrl_if #(.IMG_W(2), .IMG_H(2), .K(1), .CH(1)) tif2();

    conv2d_scan_ctrl #(.IMG_W(W), .IMG_H(H), .K(K), .CH(CH)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .tap(tif));
    conv2d_scan_ctrl #(.IMG_W(2), .IMG_H(2), .K(1), .CH(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2), .tap(tif2));

    always #5 clk = ~clk;

    typedef struct {
        int orow, ocol, ch, ky, kx, irow, icol, pad, first, last, fin;
    } desc_t;

    desc_t sb[$];
    desc_t prev;
    int    n_tests = 0, n_fail = 0, xfer_total = 0;
    bit    rnd_ready = 1'b0, exp_done = 1'b0, prev_stall = 1'b0;

    function automatic void chk(string name, int got, int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic desc_t cur();
        desc_t d;
        d.orow = int'(tif.out_row); d.ocol = int'(tif.out_col); d.ch = int'(tif.ch);
        d.ky = int'(tif.ky); d.kx = int'(tif.kx); d.irow = int'(tif.in_row);
        d.icol = int'(tif.in_col); d.pad = int'(tif.pad); d.first = int'(tif.acc_first);
        d.last = int'(tif.acc_last); d.fin = 0;
        return d;
    endfunction

    function automatic void cmp(string tag, desc_t g, desc_t e);
        chk({tag, ".out_row"}, g.orow, e.orow);
        chk({tag, ".out_col"}, g.ocol, e.ocol);
        chk({tag, ".ch"}, g.ch, e.ch);
        chk({tag, ".ky"}, g.ky, e.ky);
        chk({tag, ".kx"}, g.kx, e.kx);
        chk({tag, ".in_row"}, g.irow, e.irow);
        chk({tag, ".in_col"}, g.icol, e.icol);
        chk({tag, ".pad"}, g.pad, e.pad);
        chk({tag, ".acc_first"}, g.first, e.first);
        chk({tag, ".acc_last"}, g.last, e.last);
    endfunction

    // Reference: direct nested loops over the convolution, innermost kx.
    task automatic push_scan();
        for (int r = 0; r < OH; r++)
            for (int c = 0; c < OW; c++)
                for (int h = 0; h < CH; h++)
                    for (int y = 0; y < K; y++)
                        for (int x = 0; x < K; x++) begin
                            desc_t d;
                            int ir, ic;
                            ir = r + y - OFF;
                            ic = c + x - OFF;
                            d.orow = r; d.ocol = c; d.ch = h; d.ky = y; d.kx = x;
                            d.pad = (ir < 0 || ir >= H || ic < 0 || ic >= W) ? 1 : 0;
                            d.irow = d.pad ? 0 : ir;
                            d.icol = d.pad ? 0 : ic;
                            d.first = (x == 0 && y == 0 && h == 0) ? 1 : 0;
                            d.last = (x == K-1 && y == K-1 && h == CH-1) ? 1 : 0;
                            d.fin = (r == OH-1 && c == OW-1 && d.last == 1) ? 1 : 0;
                            sb.push_back(d);
                        end
    endtask

    always @(posedge clk) begin
        #1;
        tif.tap_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: every transfer pops the scoreboard; also checks stall hold and done timing.
    always @(negedge clk) begin
        if (reset) begin
            desc_t d;
            d = cur();
            chk("busy_vs_valid", int'(busy), int'(tif.tap_valid));
            if (exp_done) begin
                chk("done_pulse", int'(done), 1);
                chk("valid_in_done", int'(tif.tap_valid), 0);
            end else
                chk("done_idle", int'(done), 0);
            exp_done = 1'b0;
            if (prev_stall) cmp("stall_hold", d, prev);
            if (tif.tap_valid && tif.tap_ready) begin
                chk("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    desc_t e;
                    e = sb.pop_front();
                    cmp($sformatf("xfer%0d", xfer_total), d, e);
                    exp_done = (e.fin != 0);
                end
                xfer_total++;
            end
            prev_stall = tif.tap_valid && !tif.tap_ready;
            prev = d;
        end else begin
            prev_stall = 1'b0;
            exp_done = 1'b0;
        end
    end

    task automatic wait_done(input int base);
        int guard = 0;
        while (!done && guard < 20000) begin @(negedge clk); guard++; end
        chk("done_seen", int'(done), 1);
        chk("sb_empty", sb.size(), 0);
        chk("xfer_count", xfer_total - base, TOTAL);
    endtask

    task automatic run_scan(input bit rnd, input int poke_at, input bit chain);
        int base, guard;
        rnd_ready = rnd;
        if (!chain) begin @(posedge clk); #1; end
        base = xfer_total;
        push_scan();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_valid", int'(tif.tap_valid), 1);
        chk("start_busy", int'(busy), 1);
        if (poke_at >= 0) begin
            guard = 0;
            while (xfer_total - base < poke_at && guard < 5000) begin @(negedge clk); guard++; end
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done(base);
    endtask

    initial begin
        int guard, n, last_cyc, cyc;
        desc_t z;
        tif2.tap_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        z = '{default: 0};
        cmp("reset", cur(), z);
        chk("reset.valid", int'(tif.tap_valid), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        @(posedge clk); #1 reset = 1'b1;

        run_scan(1'b0, -1, 1'b0);
        run_scan(1'b1, -1, 1'b0);
        run_scan(1'b1, 5, 1'b0);
        // Start high in the DONE cycle must be ignored, then accepted in IDLE right after.
        start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("start_in_done_ignored", int'(tif.tap_valid), 0);
        run_scan(1'b0, -1, 1'b1);

        // Reset in the middle of a scan.
        rnd_ready = 1'b0;
        @(posedge clk); #1;
        n = xfer_total;
        push_scan();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        guard = 0;
        while (xfer_total - n < 20 && guard < 5000) begin @(negedge clk); guard++; end
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        sb.delete();
        @(negedge clk);
        cmp("midreset", cur(), z);
        chk("midreset.valid", int'(tif.tap_valid), 0);
        chk("midreset.busy", int'(busy), 0);
        chk("midreset.done", int'(done), 0);
        repeat (3) @(negedge clk);
        run_scan(1'b0, -1, 1'b0);

        // K=1 instance: every tap is both first and last.
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        n = 0; cyc = 0; last_cyc = -10; guard = 0;
        @(negedge clk);
        while (!done2 && guard < 100) begin
            chk("k1.busy_vs_valid", int'(busy2), int'(tif2.tap_valid));
            if (tif2.tap_valid && tif2.tap_ready) begin
                chk("k1.out_col", int'(tif2.out_col), n % 2);
                chk("k1.out_row", int'(tif2.out_row), n / 2);
                chk("k1.in_col", int'(tif2.in_col), n % 2);
                chk("k1.in_row", int'(tif2.in_row), n / 2);
                chk("k1.idx", int'({tif2.ch, tif2.ky, tif2.kx, tif2.pad}), 0);
                chk("k1.acc_first", int'(tif2.acc_first), 1);
                chk("k1.acc_last", int'(tif2.acc_last), 1);
                n++;
                last_cyc = cyc;
            end
            @(negedge clk);
            cyc++; guard++;
        end
        chk("k1.done_seen", int'(done2), 1);
        chk("k1.count", n, 4);
        chk("k1.done_latency", cyc - last_cyc, 1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/conv2d_scan_ctrl.md
# conv2d_scan_ctrl

Loop-nest sequencer for the Conv2d engine. On `start` it walks every output pixel, input channel and kernel tap in a fixed order. For each step it emits one tap descriptor (indices, input coordinates, accumulator control) over a valid/ready handshake to the MAC datapath. It replaces the hand-chained enable/reset wiring of the free-running counters with a single controller that owns all loop indices.

## Interface
- `IMG_W`, 8, input image width in pixels (≥ K)
- `IMG_H`, 8, input image height in pixels (≥ K)
- `K`, 3, square kernel size, odd, ≥ 1
- `CH`, 4, input channels per output pixel, ≥ 1
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  reset, synchronous, active-low
- `start`  in  1  launch one full scan; sampled only in IDLE
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse after final tap accepted
- `tap_valid`  out  1  descriptor on outputs is valid
- `tap_ready`  in  1  datapath accepts descriptor
- `out_row`, `out_col`  out  clog2(IMG_H), clog2(IMG_W)  output pixel coordinates
- `ch`  out  clog2(CH) (min 1)  input channel index
- `ky`, `kx`  out  clog2(K) (min 1)  kernel tap indices
- `in_row`, `in_col`  out  clog2(IMG_H), clog2(IMG_W)  input pixel to fetch; 0 when `pad`=1
- `pad`  out  1  tap lies outside image; datapath substitutes zero
- `acc_first`  out  1  first tap of this output pixel; datapath clears accumulator
- `acc_last`  out  1  last tap of this output pixel; datapath writes result

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE on acceptance (`tap_valid & tap_ready`) of the final descriptor.
  - DONE → IDLE unconditionally.
- Loop order, innermost first: `kx`, `ky`, `ch`, `out_col`, `out_row`. Each index wraps to 0 and carries into the next when it reaches its maximum.
- Maxima: `kx`,`ky` = K−1; `ch` = CH−1; `out_col` = OW−1; `out_row` = OH−1.
- OH/OW are set by the configuration (see Configuration).
- Input coordinates: `in_row` = out_row + ky − OFF, `in_col` = out_col + kx − OFF, computed at width+2 signed.
  - OFF = (K−1)/2 with padding enabled, 0 otherwise.
  - `pad`=1 if either coordinate is <0 or ≥ image dimension.
- `acc_first`=1 iff kx=ky=ch=0. `acc_last`=1 iff kx=ky=K−1 and ch=CH−1.
- Total descriptors per scan = OH·OW·CH·K·K.
- `start` in RUN or DONE is ignored; there is no queuing.

## Timing
- Reset values:
  - state IDLE; `busy`=0, `done`=0, `tap_valid`=0, `pad`=0, `acc_first`=0, `acc_last`=0.
  - all index and coordinate outputs 0.
- All outputs are registered; no combinational path from `tap_ready` to any output.
- Start: `start` high at edge N → `busy`=1 and `tap_valid`=1 from edge N+1 (one-cycle latency), with all indices 0.
- Handshake:
  - A descriptor is transferred on each edge where `tap_valid & tap_ready`. The next descriptor appears the following cycle, so throughput is one tap per clock while ready is held high.
  - While `tap_ready`=0, all descriptor outputs hold stable. `tap_valid` never drops in RUN until the final transfer.
- End of scan:
  - The cycle after the final transfer: `tap_valid`=0, `busy`=0, `done`=1 for exactly one cycle.
  - The next cycle is IDLE; `start` is accepted from then on.
- Reset mid-RUN (`reset`=0 at any edge): return to IDLE with reset values at that edge. A partial scan is discarded with no `done`.

## Configuration
- `CONV_ZERO_PAD_EN` defined: "same" convolution.
  - OH=IMG_H, OW=IMG_W, OFF=(K−1)/2.
  - Out-of-image taps are still issued with `pad`=1.
- Undefined: "valid" convolution.
  - OH=IMG_H−K+1, OW=IMG_W−K+1, OFF=0.
  - `pad` is tied 0 and the range-check logic is removed.

## Test plan
- No pad, IMG 4×4, K=3, CH=1, `tap_ready`=1, single `start`:
  - exactly 36 transfers, `acc_first` on transfers 0,9,18,27, `acc_last` on 8,17,26,35.
  - `done` one cycle after transfer 35.
- `CONV_ZERO_PAD_EN`, IMG 4×4, K=3, CH=2:
  - 288 transfers.
  - First descriptor has out(0,0), ky=kx=0, `pad`=1, in_row=in_col=0.
  - Descriptor out(0,0), ky=kx=1 has `pad`=0, in(0,0).
- Backpressure: `tap_ready` toggled pseudo-randomly (≈50%):
  - descriptors stable while stalled, none lost or duplicated.
  - Sequence identical to the ready=1 run.
- `start` pulsed at transfer 5 and in the DONE cycle → ignored; a scan launched 1 cycle after `done` starts again at all-zero indices.
- `reset`=0 at transfer 20 → next cycle IDLE, `tap_valid`=0, indices 0, no `done`; a following `start` yields a full 36-transfer scan.
- K=1, CH=1, IMG 2×2, no pad:
  - 4 transfers, each with `acc_first`=`acc_last`=1.
  - `done` after the 4th.
